ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
Two-master arbiter for the shrinked AHB port, placed between the CPU bus unit (master 0) and the DMA engine (master 1) on one side and the shared slave-side AHB on the other. It grants ownership with a bus_req/bus_ack handshake and muxes the granted master's address and control onto the bus. It routes hready, hresp and hrdata back to the granted master. Ownership changes only at a quiescent transfer boundary; an optional tenure limit forces the current owner to release the bus.

Parameters:
BUS_ADDR, 24, haddr width (32 when the MMU is present)
MAX_TENURE, 64, cycles an owner may hold the bus while the other master waits; 0 disables preemption

Ports:
clk  in  1  system clock
hreset_n  in  1  asynchronous active-low reset
m0_bus_req  in  1  master 0 (CPU) requests the bus
m0_bus_ack  out  1  master 0 granted
m0_haddr  in  BUS_ADDR  master 0 address
m0_hwrite, m0_hburst, m0_htrans  in  1 each  master 0 control (htrans=1 means active beat)
m0_hwdata  in  8  master 0 write data
m0_hready, m0_hresp  out  1 each  slave response, gated to master 0
m1_* (same set as m0_*)  -  -  master 1 (DMA)
haddr  out  BUS_ADDR  muxed address
hwrite, hburst, htrans  out  1 each  muxed control
hwdata  out  8  muxed write data
hready, hresp  in  1 each  slave response
hrdata  in  8  read data, broadcast to both masters; validity is qualified by each master's gated hready

Behaviour:
- Reset is asynchronous on hreset_n low. Grant FSM goes to IDLE, tenure counter clears, round-robin pointer is set to 1 so master 0 wins first. All outputs are 0, including both bus_ack.
- FSM states:
  - IDLE: no owner; bus parked with haddr=0, htrans=0, hwrite=0, hburst=0, hwdata=0.
  - OWN0 / OWN1: owner's signals muxed combinationally from the registered grant; bus_ackN=1.
  - DRAIN0 / DRAIN1: bus_ackN=0, but the owner's signals are still muxed until the bus is quiescent.
- Quiescent means muxed htrans=0 and hready=1 in the same cycle.
- IDLE transitions: if any request is pending, move to OWNx on the next edge. Grant latency is 1 cycle from req to bus_ack. Simultaneous requests are resolved by priority (see Optional Feature).
- OWNx stays while mx_bus_req=1 and the tenure limit has not been hit.
- OWNx goes to DRAINx when mx_bus_req falls, or when MAX_TENURE≠0, the other master is requesting, and the tenure counter has reached MAX_TENURE.
- DRAINx exit occurs on the first quiescent cycle:
  - to OWNy if the other master is requesting;
  - otherwise to OWNx if mx_bus_req is still or again high;
  - otherwise to IDLE.
- A preempted master must finish its current beat, stop issuing beats, and hold bus_req high to be re-granted.
- If hburst=1 on a beat, the drain waits for the burst's final beat (htrans=0 with hready=1). Bursts are never split.
- Tenure counter: 16 bits. It clears on entry to OWNx, increments each cycle in OWNx while the other master requests, and saturates at 0xFFFF.
- Response routing:
  - mx_hready = hready when x is the muxed master (OWNx or DRAINx), else 0.
  - mx_hresp = hresp when x is the muxed master, else 0.
  - A non-owner therefore never sees a completed beat.
- hresp=1 (error) is passed through unchanged. An error does not change ownership.
- If a requester drops req before being acked, the request is cancelled with no grant.
- A grant never changes while muxed htrans=1 and hready=0, i.e. during wait states.

Optional Feature:
ARB_RR_EN
- Defined: round-robin. On a simultaneous request, the master not granted last wins, and the pointer updates on each grant. Tenure preemption also applies.
- Undefined: fixed priority, master 0 always wins ties. Preemption applies only to master 1, so master 0 holding the bus is never preempted.

Test Plan:
- Reset, then m0_bus_req=1 at cycle 0 -> m0_bus_ack=1 at cycle 1; haddr follows m0_haddr=0x001234; m1_hready=0 throughout.
- Both requests raised in the same cycle from IDLE -> without ARB_RR_EN, m0 is granted every time across 3 release/re-request rounds; with ARB_RR_EN, grants alternate m0, m1, m0.
- m0 owns the bus, slave holds hready=0 for 3 cycles on an active beat while m0 drops req -> grant is held until hready=1 with htrans=0; then m1 is granted on the next edge.
- MAX_TENURE=4, m1 owns the bus continuously while m0 requests -> m1_bus_ack falls after 4 waiting cycles; m0_bus_ack rises on the first quiescent cycle after that.
- 4-beat burst by m1 (hburst=1), with m0 requesting mid-burst under preemption -> no handover until the final beat completes; haddr shows all 4 m1 addresses.
- hreset_n pulsed low mid-transfer while OWN1 -> next sample shows all outputs 0 and state IDLE; after reset release, m1 re-request is granted in 1 cycle.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter: bus_req/bus_ack grant FSM, address/control mux, response gating.
// Optional ARB_RR_EN selects round-robin tie-break (and lets master 0 be preempted too).
module ahb_bus_arbiter #(
    parameter int BUS_ADDR   = 24,
    parameter int MAX_TENURE = 64
) (
    input  logic                clk,
    input  logic                hreset_n,
    input  logic                m0_bus_req,
    output logic                m0_bus_ack,
    input  logic [BUS_ADDR-1:0] m0_haddr,
    input  logic                m0_hwrite,
    input  logic                m0_hburst,
    input  logic                m0_htrans,
    input  logic [7:0]          m0_hwdata,
    output logic                m0_hready,
    output logic                m0_hresp,
    output logic [7:0]          m0_hrdata,
    input  logic                m1_bus_req,
    output logic                m1_bus_ack,
    input  logic [BUS_ADDR-1:0] m1_haddr,
    input  logic                m1_hwrite,
    input  logic                m1_hburst,
    input  logic                m1_htrans,
    input  logic [7:0]          m1_hwdata,
    output logic                m1_hready,
    output logic                m1_hresp,
    output logic [7:0]          m1_hrdata,
    output logic [BUS_ADDR-1:0] haddr,
    output logic                hwrite,
    output logic                hburst,
    output logic                htrans,
    output logic [7:0]          hwdata,
    input  logic                hready,
    input  logic                hresp,
    input  logic [7:0]          hrdata
);
    typedef enum logic [2:0] {IDLE, OWN0, OWN1, DRAIN0, DRAIN1} state_t;

    localparam logic [15:0] TEN_LIM = 16'(MAX_TENURE);

    state_t      state, state_nxt;
    logic [15:0] tenure;
    logic        sel0, sel1, quiet, hit, pre0, pre1, pick1;

    assign sel0       = (state == OWN0) || (state == DRAIN0);
    assign sel1       = (state == OWN1) || (state == DRAIN1);
    assign m0_bus_ack = (state == OWN0);
    assign m1_bus_ack = (state == OWN1);

    always_comb begin
        haddr  = '0;
        hwrite = 1'b0;
        hburst = 1'b0;
        htrans = 1'b0;
        hwdata = '0;
        if (sel0) begin
            haddr  = m0_haddr;
            hwrite = m0_hwrite;
            hburst = m0_hburst;
            htrans = m0_htrans;
            hwdata = m0_hwdata;
        end else if (sel1) begin
            haddr  = m1_haddr;
            hwrite = m1_hwrite;
            hburst = m1_hburst;
            htrans = m1_htrans;
            hwdata = m1_hwdata;
        end
    end

    // A non-owner never sees a completed beat or an error.
    assign m0_hready = sel0 & hready;
    assign m1_hready = sel1 & hready;
    assign m0_hresp  = sel0 & hresp;
    assign m1_hresp  = sel1 & hresp;
    assign m0_hrdata = hrdata;
    assign m1_hrdata = hrdata;

    // Also covers bursts: the final beat is the first htrans=0 with hready=1.
    assign quiet = !htrans && hready;
    assign hit   = (MAX_TENURE != 0) && (tenure >= TEN_LIM);
    assign pre1  = hit && m0_bus_req;

`ifdef ARB_RR_EN
    logic last;
    assign pick1 = !last;
    assign pre0  = hit && m1_bus_req;

    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n)
            last <= 1'b1;
        else if (state_nxt != state && state_nxt == OWN0)
            last <= 1'b0;
        else if (state_nxt != state && state_nxt == OWN1)
            last <= 1'b1;
    end
`else
    assign pick1 = 1'b0;
    assign pre0  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_bus_req && m1_bus_req) state_nxt = pick1 ? OWN1 : OWN0;
                else if (m0_bus_req)          state_nxt = OWN0;
                else if (m1_bus_req)          state_nxt = OWN1;
            end
            OWN0: if (!m0_bus_req || pre0) state_nxt = DRAIN0;
            OWN1: if (!m1_bus_req || pre1) state_nxt = DRAIN1;
            DRAIN0: begin
                if (quiet) begin
                    if (m1_bus_req)      state_nxt = OWN1;
                    else if (m0_bus_req) state_nxt = OWN0;
                    else                 state_nxt = IDLE;
                end
            end
            DRAIN1: begin
                if (quiet) begin
                    if (m0_bus_req)      state_nxt = OWN0;
                    else if (m1_bus_req) state_nxt = OWN1;
                    else                 state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n) begin
            state  <= IDLE;
            tenure <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt == OWN0 || state_nxt == OWN1) && state_nxt != state)
                tenure <= '0;
            else if (((state == OWN0 && m1_bus_req) || (state == OWN1 && m0_bus_req))
                     && tenure != 16'hFFFF)
                tenure <= tenure + 16'd1;
        end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter (MAX_TENURE=4, BUS_ADDR=24).
module tb_ahb_bus_arbiter;
    logic        clk = 1'b0;
    logic        hreset_n;
    logic        m0_bus_req, m0_bus_ack, m0_hwrite, m0_hburst, m0_htrans, m0_hready, m0_hresp;
    logic        m1_bus_req, m1_bus_ack, m1_hwrite, m1_hburst, m1_htrans, m1_hready, m1_hresp;
    logic [23:0] m0_haddr, m1_haddr, haddr;
    logic [7:0]  m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata, hwdata, hrdata;
    logic        hwrite, hburst, htrans, hready, hresp;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ahb_bus_arbiter #(.BUS_ADDR(24), .MAX_TENURE(4)) dut (
        .clk(clk), .hreset_n(hreset_n),
        .m0_bus_req(m0_bus_req), .m0_bus_ack(m0_bus_ack), .m0_haddr(m0_haddr),
        .m0_hwrite(m0_hwrite), .m0_hburst(m0_hburst), .m0_htrans(m0_htrans),
        .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
        .m1_bus_req(m1_bus_req), .m1_bus_ack(m1_bus_ack), .m1_haddr(m1_haddr),
        .m1_hwrite(m1_hwrite), .m1_hburst(m1_hburst), .m1_htrans(m1_htrans),
        .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
        .haddr(haddr), .hwrite(hwrite), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_bus_req = 0; m0_haddr = '0; m0_hwrite = 0; m0_hburst = 0; m0_htrans = 0; m0_hwdata = '0;
        m1_bus_req = 0; m1_haddr = '0; m1_hwrite = 0; m1_hburst = 0; m1_htrans = 0; m1_hwdata = '0;
        hready = 1; hresp = 0; hrdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        hreset_n = 0;
        tick();
        hreset_n = 1;
    endtask

    task automatic release_all();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        m0_bus_req = 1; m0_haddr = 24'h00ABCD; m0_htrans = 1; m0_hwrite = 1; m0_hwdata = 8'h77;
        hresp = 1;
        hreset_n = 0;
        tick();
        tick();
        checks++; if (m0_bus_ack !== 1'b0) begin failures++; $display("FAIL rst_ack0 got=%0b exp=0", m0_bus_ack); end
        checks++; if (m1_bus_ack !== 1'b0) begin failures++; $display("FAIL rst_ack1 got=%0b exp=0", m1_bus_ack); end
        checks++; if (haddr !== 24'h0) begin failures++; $display("FAIL rst_haddr got=%h exp=0", haddr); end
        checks++; if ({htrans, hwrite, hburst} !== 3'b000) begin failures++; $display("FAIL rst_ctrl got=%b exp=000", {htrans, hwrite, hburst}); end
        checks++; if (hwdata !== 8'h0) begin failures++; $display("FAIL rst_hwdata got=%h exp=0", hwdata); end
        checks++; if ({m0_hready, m1_hready, m0_hresp, m1_hresp} !== 4'b0000) begin failures++; $display("FAIL rst_resp got=%b exp=0000", {m0_hready, m1_hready, m0_hresp, m1_hresp}); end
        clear_inputs();
        hreset_n = 1;
    endtask

    task automatic test_grant();
        m0_bus_req = 1; m0_haddr = 24'h001234;
        #1;
        checks++; if (m0_bus_ack !== 1'b0) begin failures++; $display("FAIL grant_cycle0 got=%0b exp=0", m0_bus_ack); end
        tick();
        checks++; if (m0_bus_ack !== 1'b1) begin failures++; $display("FAIL grant_ack0 got=%0b exp=1", m0_bus_ack); end
        checks++; if (haddr !== 24'h001234) begin failures++; $display("FAIL grant_haddr got=%h exp=001234", haddr); end
        checks++; if (m0_hready !== 1'b1) begin failures++; $display("FAIL grant_m0_hready got=%0b exp=1", m0_hready); end
        checks++; if (m1_hready !== 1'b0) begin failures++; $display("FAIL grant_m1_hready got=%0b exp=0", m1_hready); end
        hresp = 1; hrdata = 8'hC3;
        #1;
        checks++; if (m0_hresp !== 1'b1 || m1_hresp !== 1'b0) begin failures++; $display("FAIL err_route got=%b%b exp=10", m0_hresp, m1_hresp); end
        checks++; if (m0_hrdata !== 8'hC3 || m1_hrdata !== 8'hC3) begin failures++; $display("FAIL rdata_bcast got=%h/%h exp=c3", m0_hrdata, m1_hrdata); end
        tick();
        checks++; if (m0_bus_ack !== 1'b1) begin failures++; $display("FAIL err_keeps_grant got=%0b exp=1", m0_bus_ack); end
        checks++; if (m1_hready !== 1'b0) begin failures++; $display("FAIL grant_m1_hready2 got=%0b exp=0", m1_hready); end
        release_all();
        checks++; if (haddr !== 24'h0 || m0_bus_ack !== 1'b0) begin failures++; $display("FAIL park_idle haddr=%h ack0=%0b exp 0/0", haddr, m0_bus_ack); end
    endtask

    task automatic test_priority();
        logic exp0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
`ifdef ARB_RR_EN
            exp0 = (r != 1);
`else
            exp0 = 1'b1;
`endif
            m0_bus_req = 1; m1_bus_req = 1;
            tick();
            checks++; if (m0_bus_ack !== exp0 || m1_bus_ack !== !exp0) begin failures++; $display("FAIL prio_round%0d got=%b%b exp=%b%b", r, m0_bus_ack, m1_bus_ack, exp0, !exp0); end
            release_all();
        end
    endtask

    task automatic test_drain_wait();
        do_reset();
        m0_bus_req = 1;
        tick();
        m0_bus_req = 0; m1_bus_req = 1; m0_htrans = 1; m0_haddr = 24'hABCDE0; m1_haddr = 24'h000555; hready = 0;
        tick();
        checks++; if (m0_bus_ack !== 1'b0 || m1_bus_ack !== 1'b0) begin failures++; $display("FAIL drain_acks got=%b%b exp=00", m0_bus_ack, m1_bus_ack); end
        checks++; if (haddr !== 24'hABCDE0) begin failures++; $display("FAIL drain_haddr got=%h exp=abcde0", haddr); end
        checks++; if (m0_hready !== 1'b0) begin failures++; $display("FAIL drain_m0_hready got=%0b exp=0", m0_hready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (m1_bus_ack !== 1'b0 || haddr !== 24'hABCDE0) begin failures++; $display("FAIL wait_hold%0d ack1=%0b haddr=%h exp 0/abcde0", i, m1_bus_ack, haddr); end
        end
        hready = 1; m0_htrans = 0;
        #1;
        checks++; if (m0_hready !== 1'b1 || m1_bus_ack !== 1'b0) begin failures++; $display("FAIL quiet_cycle m0_hready=%0b ack1=%0b exp 1/0", m0_hready, m1_bus_ack); end
        tick();
        checks++; if (m1_bus_ack !== 1'b1 || haddr !== 24'h000555) begin failures++; $display("FAIL handover ack1=%0b haddr=%h exp 1/000555", m1_bus_ack, haddr); end
        release_all();
    endtask

    task automatic test_tenure();
        do_reset();
        m1_bus_req = 1;
        tick();
        m0_bus_req = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (m1_bus_ack !== 1'b1) begin failures++; $display("FAIL tenure_hold%0d got=%0b exp=1", i, m1_bus_ack); end
        end
        tick();
        checks++; if (m1_bus_ack !== 1'b0 || m0_bus_ack !== 1'b0) begin failures++; $display("FAIL tenure_drop got=%b%b exp=00", m0_bus_ack, m1_bus_ack); end
        tick();
        checks++; if (m0_bus_ack !== 1'b1) begin failures++; $display("FAIL tenure_regrant got=%0b exp=1", m0_bus_ack); end
        release_all();
    endtask

    task automatic test_burst();
        logic [23:0] a;
        do_reset();
        m1_bus_req = 1;
        tick();
        m0_bus_req = 1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            a = 24'h000100 + 24'(4 * i);
            m1_haddr = a; m1_htrans = 1; m1_hburst = 1;
            #1;
            checks++; if (haddr !== a) begin failures++; $display("FAIL burst_haddr%0d got=%h exp=%h", i, haddr, a); end
            checks++; if (m0_bus_ack !== 1'b0) begin failures++; $display("FAIL burst_nosplit%0d got=%0b exp=0", i, m0_bus_ack); end
            if (i == 2) begin
                checks++; if (m1_bus_ack !== 1'b1) begin failures++; $display("FAIL burst_owner got=%0b exp=1", m1_bus_ack); end
            end
            if (i == 3) begin
                checks++; if (m1_bus_ack !== 1'b0 || m1_hready !== 1'b1) begin failures++; $display("FAIL burst_drain ack1=%0b m1_hready=%0b exp 0/1", m1_bus_ack, m1_hready); end
            end
            tick();
        end
        m1_htrans = 0; m1_hburst = 0;
        #1;
        checks++; if (m0_bus_ack !== 1'b0) begin failures++; $display("FAIL burst_final got=%0b exp=0", m0_bus_ack); end
        tick();
        checks++; if (m0_bus_ack !== 1'b1) begin failures++; $display("FAIL burst_handover got=%0b exp=1", m0_bus_ack); end
        release_all();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_bus_req = 1;
        tick();
        m1_haddr = 24'h00BEEF; m1_htrans = 1; m1_hwrite = 1; m1_hwdata = 8'h5A;
        #1;
        checks++; if (haddr !== 24'h00BEEF) begin failures++; $display("FAIL mid_pre got=%h exp=00beef", haddr); end
        #2;
        hreset_n = 0;
        #1;
        checks++; if (m1_bus_ack !== 1'b0 || m1_hready !== 1'b0) begin failures++; $display("FAIL mid_rst_ack ack1=%0b hready1=%0b exp 0/0", m1_bus_ack, m1_hready); end
        checks++; if (haddr !== 24'h0 || hwdata !== 8'h0 || {htrans, hwrite} !== 2'b00) begin failures++; $display("FAIL mid_rst_bus haddr=%h hwdata=%h ctrl=%b%b exp 0", haddr, hwdata, htrans, hwrite); end
        tick();
        hreset_n = 1;
        tick();
        checks++; if (m1_bus_ack !== 1'b1 || haddr !== 24'h00BEEF) begin failures++; $display("FAIL mid_regrant ack1=%0b haddr=%h exp 1/00beef", m1_bus_ack, haddr); end
        release_all();
    endtask

    initial begin
        clear_inputs();
        hreset_n = 1;
        test_reset();
        test_grant();
        test_priority();
        test_drain_wait();
        test_tenure();
        test_burst();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
